uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Frame-sequencing controller for the UART receiver. Watches the serial line and the edge/bit counter outputs, enables the counter for the length of a frame, and issues per-bit strobes to the sampler, deserializer and start/parity/stop checkers. It raises `data_valid` for one cycle when a frame completes without error. It sits between `rx_in` and the receiver datapath and is the only block that drives the counter enable.

## Interface
Parameters:
- `PRESCALE_W`, 6: width of `prescale` and `edge_count`.
- `BIT_CNT_W`, 4: width of `bit_count`.

Ports:
- `clk`  in  1  receiver clock (oversampling clock).
- `rst`  in  1  reset, synchronous, active-high.
- `rx_in`  in  1  serial line, idle high.
- `par_en`  in  1  parity frame enabled.
- `prescale`  in  6  oversampling ratio; legal values are 8, 16 and 32.
- `edge_count`  in  6  from edge/bit counter; runs 1..`prescale` while enabled, 0 when disabled.
- `bit_count`  in  4  from edge/bit counter; 1 = start bit, 2..9 = data, 10 = parity/stop, 11 = stop.
- `strt_glitch`, `par_err`, `stp_err`  in  1  combinational checker results, valid in the same cycle as the matching check enable.
- `cnt_enable`  out  1  edge/bit counter enable.
- `samp_en`  out  1  sampler majority-window enable.
- `deser_en`  out  1  shift strobe to the deserializer.
- `strt_chk_en`, `par_chk_en`, `stp_chk_en`  out  1  checker strobes.
- `data_valid`  out  1  one-cycle frame-good pulse.
- `par_error`, `frame_error`  out  1  error status (see Configuration).

## Operation
- States: IDLE, START, DATA, PARITY, STOP, CHECK. State is held in a register; all outputs are decoded from it.
- "End of bit" means `edge_count == prescale`.
- **IDLE:** `cnt_enable` = 0. Move to START when `rx_in` = 0.
- **START:** `cnt_enable` = 1.
  - At end of bit with `bit_count` = 1, assert `strt_chk_en`.
  - If `strt_glitch` = 1, go to IDLE. Otherwise go to DATA.
- **DATA:** assert `deser_en` at each end of bit.
  - At end of bit with `bit_count` = 9, go to PARITY if `par_en`, else go to STOP.
- **PARITY:** at end of bit, assert `par_chk_en`, latch `par_err` into `par_flag`, and go to STOP.
- **STOP:** at end of bit, assert `stp_chk_en`, latch `stp_err` into `stp_flag`, and go to CHECK.
- **CHECK** (one cycle): `cnt_enable` = 0, so the counter clears.
  - `data_valid` = !`par_flag` && !`stp_flag`.
  - Go to START if `rx_in` = 0 (back-to-back frame). Otherwise go to IDLE.
- `samp_en` = 1 in START/DATA/PARITY/STOP while `edge_count` ∈ {`prescale`/2−1, `prescale`/2, `prescale`/2+1}. Halving is done by a right shift; no divider.
- `par_flag` and `stp_flag` clear on every entry to START.
- `par_en` and `prescale` are sampled live. Changing them mid-frame is illegal and the resulting behaviour is undefined.
- Reset mid-frame: the next cycle is IDLE with all strobes 0. A low `rx_in` at that point starts a new frame.

## Timing
- Reset values: state IDLE; every output 0; both flags 0.
- IDLE→START latency: 1 cycle after `rx_in` falls.
- All strobes are one cycle wide and coincident with end of bit, except `samp_en`, which is 3 cycles wide.
- `data_valid` is high exactly one cycle, in the CHECK cycle, 1 cycle after the STOP end-of-bit cycle.
- If `rx_in` is low in CHECK, START is entered with no IDLE cycle.
- A glitched start returns to IDLE with no `data_valid`, no `deser_en` and no flag update.

## Configuration
- `UART_RX_ERR_STATUS_EN` defined:
  - `par_error` and `frame_error` pulse in the CHECK cycle with `par_flag` and `stp_flag` respectively.
  - They also pulse on the glitch abort: `frame_error` = 1 in the cycle after `strt_chk_en` with `strt_glitch`.
- Not defined: both ports are tied to 0.
- In both cases an errored frame suppresses `data_valid`.

## Structure
- Shared package `uart_rx_pkg` holds:
  - state enum `uart_rx_state_t`;
  - constants `START_BIT` = 1, `LAST_DATA_BIT` = 9, `PARITY_BIT` = 10;
  - `PRESCALE_W`.
- One sub-module, `uart_rx_samp_window`: combinational decoder of `edge_count`/`prescale` into `samp_en` and end of bit.

## Test plan
- `prescale` = 8, `par_en` = 0, frame 0xA5 → 8 `deser_en` pulses, no `par_chk_en`, `data_valid` once, and `frame_error` = 0.
- `prescale` = 16, `par_en` = 1, `par_err` forced 1 at `par_chk_en` → `data_valid` never asserts; `par_error` pulses in CHECK (with macro).
- 3-cycle low pulse on `rx_in` with `strt_glitch` = 1 at `strt_chk_en` → return to IDLE; zero `deser_en`; `frame_error` pulse (with macro).
- Two back-to-back frames, `prescale` = 32, `rx_in` low in CHECK → CHECK→START directly; two `data_valid` pulses.
- `rst` asserted during DATA bit 5 → next cycle IDLE, all outputs 0; a subsequent clean frame is received correctly.
- `prescale` = 8 → `samp_en` high exactly on `edge_count` 3, 4, 5 of every bit.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver frame controller.
package uart_rx_pkg;

  localparam int PRESCALE_W = 6;
  localparam int BIT_CNT_W  = 4;

  // Bit positions reported by the edge/bit counter
  localparam logic [BIT_CNT_W-1:0] START_BIT     = 4'd1;
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = 4'd9;
  localparam logic [BIT_CNT_W-1:0] PARITY_BIT    = 4'd10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    CHECK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_samp_window.sv
// Decodes the edge counter into the sampler's three-edge majority window
// around mid-bit and the end-of-bit marker.
module uart_rx_samp_window #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  active,
  input  logic [PRESCALE_W-1:0] edge_count,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  samp_en,
  output logic                  end_of_bit
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] half;

  // Window is centred on prescale/2; a shift keeps the halving free of dividers
  always_comb begin
    half       = prescale >> 1;
    end_of_bit = (edge_count == prescale);
    samp_en    = active && ((edge_count == half - ONE) ||
                            (edge_count == half) ||
                            (edge_count == half + ONE));
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Frame-sequencing controller for the UART receiver. Enables the edge/bit
// counter for one frame, strobes the sampler, deserializer and checkers,
// and reports a good frame with a one-cycle data_valid.
// Optional error status outputs: define UART_RX_ERR_STATUS_EN.
module uart_rx_ctrl #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_count,
  input  logic [BIT_CNT_W-1:0]  bit_count,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  cnt_enable,
  output logic                  samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  par_error,
  output logic                  frame_error
);

  import uart_rx_pkg::*;

  uart_rx_state_t state, next_state;
  logic           par_flag, stp_flag;
  logic           frame_active;
  logic           end_of_bit;
  logic           enter_start;

  assign frame_active = (state == START) || (state == DATA) ||
                        (state == PARITY) || (state == STOP);
  assign enter_start  = (next_state == START) && (state != START);

  uart_rx_samp_window #(
    .PRESCALE_W (PRESCALE_W)
  ) u_samp_window (
    .active     (frame_active),
    .edge_count (edge_count),
    .prescale   (prescale),
    .samp_en    (samp_en),
    .end_of_bit (end_of_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Error flags are cleared at frame start and captured on their check strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      par_flag <= 1'b0;
      stp_flag <= 1'b0;
    end else if (enter_start) begin
      par_flag <= 1'b0;
      stp_flag <= 1'b0;
    end else begin
      if (par_chk_en) par_flag <= par_err;
      if (stp_chk_en) stp_flag <= stp_err;
    end
  end

  // Next-state and strobe decode; every strobe fires only at end of bit
  always_comb begin
    next_state  = state;
    cnt_enable  = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_in) next_state = START;
      end
      START: begin
        cnt_enable = 1'b1;
        if (end_of_bit && (bit_count == START_BIT)) begin
          strt_chk_en = 1'b1;
          next_state  = strt_glitch ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_enable = 1'b1;
        if (end_of_bit) begin
          deser_en = 1'b1;
          if (bit_count == LAST_DATA_BIT) next_state = par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        cnt_enable = 1'b1;
        if (end_of_bit) begin
          par_chk_en = 1'b1;
          next_state = STOP;
        end
      end
      STOP: begin
        cnt_enable = 1'b1;
        if (end_of_bit) begin
          stp_chk_en = 1'b1;
          next_state = CHECK;
        end
      end
      CHECK: begin
        data_valid = !par_flag && !stp_flag;
        next_state = rx_in ? IDLE : START;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef UART_RX_ERR_STATUS_EN
  logic glitch_abort;

  // Remember a glitched start so frame_error can pulse in the following cycle
  always_ff @(posedge clk) begin
    if (rst) glitch_abort <= 1'b0;
    else     glitch_abort <= strt_chk_en && strt_glitch;
  end

  assign par_error   = (state == CHECK) && par_flag;
  assign frame_error = ((state == CHECK) && stp_flag) || glitch_abort;
`else
  assign par_error   = 1'b0;
  assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a behavioural edge/bit counter.
// Frame results are pushed to a scoreboard when a frame is issued and
// popped by an independent monitor at each frame end.
module tb_uart_rx_ctrl;

`ifdef UART_RX_ERR_STATUS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic [5:0] prescale;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       strt_glitch, par_err, stp_err;
  logic       cnt_enable, samp_en, deser_en;
  logic       strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, par_error, frame_error;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       dv;
    logic       pe;
    logic       fe;
    logic       cnt;
    logic [3:0] deser;
    logic [3:0] parchk;
  } frame_exp_t;

  frame_exp_t exp_q[$];

  uart_rx_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .prescale    (prescale),
    .edge_count  (edge_count),
    .bit_count   (bit_count),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .cnt_enable  (cnt_enable),
    .samp_en     (samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .par_error   (par_error),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  // Edge/bit counter model: 1..prescale per bit, cleared while disabled
  always @(posedge clk) begin
    if (rst || !cnt_enable) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (edge_count == 6'd0) begin
      edge_count <= 6'd1;
      bit_count  <= 4'd1;
    end else if (edge_count == prescale) begin
      edge_count <= 6'd1;
      bit_count  <= bit_count + 4'd1;
    end else begin
      edge_count <= edge_count + 6'd1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: per-cycle strobe/window checks plus scoreboard pop at frame end
  bit         prev_stp = 1'b0, prev_abort = 1'b0, prev_cnt = 1'b0;
  bit         is_end, samp_exp, ok;
  int         deser_cnt = 0, parchk_cnt = 0;
  int         e2, p;
  frame_exp_t got_e, exp_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stp   = 1'b0;
      prev_abort = 1'b0;
      prev_cnt   = 1'b0;
    end else begin
      is_end = prev_stp || prev_abort;
      if (cnt_enable && !prev_cnt) begin
        deser_cnt  = 0;
        parchk_cnt = 0;
      end
      if (deser_en)   deser_cnt++;
      if (par_chk_en) parchk_cnt++;
      e2 = 2 * int'(edge_count);
      p  = int'(prescale);
      samp_exp = cnt_enable && (e2 >= p - 2) && (e2 <= p + 2);
      ok = (samp_en === samp_exp) &&
           (!(deser_en || strt_chk_en || par_chk_en || stp_chk_en) ||
            (edge_count == prescale)) &&
           (is_end || !(data_valid || par_error || frame_error));
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL cycle_check edge=%0d ps=%0d samp=%b/%b strobes=%b%b%b%b status=%b%b%b end=%b",
                 edge_count, prescale, samp_en, samp_exp, deser_en, strt_chk_en,
                 par_chk_en, stp_chk_en, data_valid, par_error, frame_error, is_end);
      end
      if (is_end) begin
        got_e = '{dv: data_valid, pe: par_error, fe: frame_error, cnt: cnt_enable,
                  deser: 4'(deser_cnt), parchk: 4'(parchk_cnt)};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL frame_unexpected actual=%0h expected=none", got_e);
        end else begin
          exp_e = exp_q.pop_front();
          if (got_e !== exp_e) begin
            errors++;
            $display("[TB] FAIL frame_result actual dv%b pe%b fe%b cnt%b deser%0d par%0d expected dv%b pe%b fe%b cnt%b deser%0d par%0d",
                     got_e.dv, got_e.pe, got_e.fe, got_e.cnt, got_e.deser, got_e.parchk,
                     exp_e.dv, exp_e.pe, exp_e.fe, exp_e.cnt, exp_e.deser, exp_e.parchk);
          end
        end
      end
      prev_stp   = stp_chk_en;
      prev_abort = strt_chk_en && strt_glitch;
      prev_cnt   = cnt_enable;
    end
  end

  // Issue one frame and push its hand-computed result to the scoreboard
  task automatic applyStimulus(input logic [5:0] ps, input bit pe, input bit glitch,
                               input bit perr, input bit serr, input bit chain_in,
                               input bit chain_out, input frame_exp_t expected);
    int n;
    exp_q.push_back(expected);
    prescale    = ps;
    par_en      = pe;
    strt_glitch = glitch;
    par_err     = perr;
    stp_err     = serr;
    if (!chain_in) begin
      checkOutput("idle_before_start", 32'(cnt_enable), 32'd0);
      rx_in = 1'b0;
      @(negedge clk);
      checkOutput("idle_to_start_latency", 32'(cnt_enable), 32'd1);
      repeat (2) @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
    end
    rx_in = 1'b1;
    n = 0;
    if (glitch) begin
      while (!strt_chk_en && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (!strt_chk_en) checkOutput("start_check_timeout", 32'd0, 32'd1);
      @(negedge clk);
      repeat (3) @(negedge clk);
      checkOutput("glitch_back_idle", 32'(cnt_enable), 32'd0);
    end else begin
      while (!stp_chk_en && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (!stp_chk_en) begin
        checkOutput("stop_check_timeout", 32'd0, 32'd1);
      end else begin
        rx_in = chain_out ? 1'b0 : 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput(chain_out ? "check_to_start" : "check_to_idle",
                    32'(cnt_enable), chain_out ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    rx_in = 1'b1;
    par_en = 1'b0;
    prescale = 6'd8;
    strt_glitch = 1'b0;
    par_err = 1'b0;
    stp_err = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {23'd0, cnt_enable, samp_en, deser_en, strt_chk_en, par_chk_en,
                 stp_chk_en, data_valid, par_error, frame_error}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean 8x frame, no parity
    applyStimulus(6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  '{dv: 1'b1, pe: 1'b0, fe: 1'b0, cnt: 1'b0, deser: 4'd8, parchk: 4'd0});
    repeat (3) @(negedge clk);
    // 16x frame with parity error
    applyStimulus(6'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                  '{dv: 1'b0, pe: ERR_EN, fe: 1'b0, cnt: 1'b0, deser: 4'd8, parchk: 4'd1});
    repeat (3) @(negedge clk);
    // Glitched start bit
    applyStimulus(6'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                  '{dv: 1'b0, pe: 1'b0, fe: ERR_EN, cnt: 1'b0, deser: 4'd0, parchk: 4'd0});
    repeat (3) @(negedge clk);
    // Stop bit error
    applyStimulus(6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                  '{dv: 1'b0, pe: 1'b0, fe: ERR_EN, cnt: 1'b0, deser: 4'd8, parchk: 4'd0});
    repeat (3) @(negedge clk);
    // Back-to-back 32x frames
    applyStimulus(6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  '{dv: 1'b1, pe: 1'b0, fe: 1'b0, cnt: 1'b0, deser: 4'd8, parchk: 4'd0});
    applyStimulus(6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                  '{dv: 1'b1, pe: 1'b0, fe: 1'b0, cnt: 1'b0, deser: 4'd8, parchk: 4'd0});
    repeat (3) @(negedge clk);

    // Reset during data bit 5, then a clean parity frame
    prescale = 6'd16;
    par_en   = 1'b0;
    rx_in    = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    n = 0;
    while (!(cnt_enable && bit_count == 4'd5) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_bit5", 32'(bit_count), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midframe_reset_outputs",
                {23'd0, cnt_enable, samp_en, deser_en, strt_chk_en, par_chk_en,
                 stp_chk_en, data_valid, par_error, frame_error}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(6'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  '{dv: 1'b1, pe: 1'b0, fe: 1'b0, cnt: 1'b0, deser: 4'd8, parchk: 4'd1});
    repeat (5) @(negedge clk);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
